tm_master_multislave_rob: RTL and testbench

Credit shell for a master that issues requests to several slaves and receives replies out of order. It tags each request and holds a credit counter sized to a tag-indexed reorder buffer (ROB). Replies are delivered to the master module in issue order, with full backpressure from the module. It sits between the master module and its pkt/dpkt NoC interfaces, and adds two features: a run-time-selectable reorder/arrival-order mode and sticky error flags.

---
 rtl/tm_rob_pkg.sv | 15 +
 rtl/tm_credit_counter.sv | 62 ++++++
 rtl/tm_master_multislave_rob.sv | 148 ++++++++++++++
 tb/tb_tm_master_multislave_rob.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_rob_pkg.sv
// Shared constants for the master-side credit/reorder shell.
package tm_rob_pkg;

   // Bit positions inside err_flags.
   localparam int ERR_COLLISION = 0;
   localparam int ERR_UNDERFLOW = 1;
   localparam int ERR_OVERFLOW  = 2;
   localparam int ERR_W         = 3;

   // Width of a ROB slot index; NUM_CREDITS is a power of two, at least 2.
   function automatic int slot_w(input int num_credits);
      return $clog2(num_credits);
   endfunction

endpackage

// File: rtl/tm_credit_counter.sv
// Credit counter: gates the send handshake and flags counter misuse.
module tm_credit_counter
   import tm_rob_pkg::*;
#(
   parameter int NUM_CREDITS = 8,
   parameter int CNT_W       = slot_w(NUM_CREDITS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             send_valid_in,
   input  logic             send_ready_in,
   input  logic             deliver,
   output logic             send_ready_out,
   output logic             issue,
   output logic [CNT_W-1:0] credits_avail,
   output logic             err_underflow,
   output logic             err_overflow
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CREDITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             under_q, under_d;
   logic             over_q, over_d;

   assign send_ready_out = (cnt_q != '0) & send_ready_in;
   assign issue          = send_valid_in & send_ready_out;
   assign credits_avail  = cnt_q;
   assign err_underflow  = under_q;
   assign err_overflow   = over_q;

   // Next counter value; an issue and a delivery in the same cycle cancel.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      cnt_d   = cnt_q;
      under_d = under_q;
      over_d  = over_q;
      if (issue && !deliver) begin
         if (cnt_q == '0) under_d = 1'b1;
         else             cnt_d   = cnt_q - CNT_ONE;
      end else if (deliver && !issue) begin
         if (cnt_q == CNT_FULL) over_d = 1'b1;
         else                   cnt_d  = cnt_q + CNT_ONE;
      end
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         cnt_q   <= CNT_FULL;
         under_q <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         under_q <= under_d;
         over_q  <= over_d;
      end
   end

endmodule

// File: rtl/tm_master_multislave_rob.sv
// Master-side shell: tags requests, holds credits, and returns out-of-order
// replies either in tag order (reorder mode) or in arrival order.
module tm_master_multislave_rob
   import tm_rob_pkg::*;
#(
   parameter int NUM_CREDITS = 8,
   parameter int WIDTH_DATA  = 36,
   parameter int WIDTH_TAG   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          reorder_en,
   input  logic                          send_valid_in,
   input  logic                          send_ready_in,
   output logic                          send_ready_out,
   output logic [WIDTH_TAG-1:0]          send_tag,
   input  logic                          receive_valid_in,
   input  logic [WIDTH_TAG-1:0]          receive_tag,
   input  logic [WIDTH_DATA-1:0]         receive_data_in,
   output logic                          receive_ready_out,
   output logic                          receive_valid_out,
   output logic [WIDTH_DATA-1:0]         receive_data_out,
   input  logic                          receive_ready_in,
   output logic [slot_w(NUM_CREDITS):0]  credits_avail,
   output logic [ERR_W-1:0]              err_flags
);

   localparam int SLOT_W = slot_w(NUM_CREDITS);
   localparam int CNT_W  = SLOT_W + 1;

   logic                  issue, deliver, load;
   logic                  err_underflow, err_overflow;
   logic                  mode_q, mode_d;
   logic [WIDTH_TAG-1:0]  send_tag_q, send_tag_d;
   logic [WIDTH_TAG-1:0]  head_tag_q, head_tag_d;
   logic [SLOT_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [SLOT_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [SLOT_W-1:0]     wr_slot, rd_slot;
   logic [NUM_CREDITS-1:0] rob_valid_q, rob_valid_d;
   logic [WIDTH_DATA-1:0] rob_data_q [NUM_CREDITS];
   logic                  rx_valid_q, rx_valid_d;
   logic [WIDTH_DATA-1:0] rx_data_q, rx_data_d;
   logic                  collision_q, collision_d;
   logic                  unused_tag_bits;

   tm_credit_counter #(
      .NUM_CREDITS (NUM_CREDITS),
      .CNT_W       (CNT_W)
   ) u_credit (
      .clk            (clk),
      .rst            (rst),
      .send_valid_in  (send_valid_in),
      .send_ready_in  (send_ready_in),
      .deliver        (deliver),
      .send_ready_out (send_ready_out),
      .issue          (issue),
      .credits_avail  (credits_avail),
      .err_underflow  (err_underflow),
      .err_overflow   (err_overflow)
   );

   // Credits reserve a slot for every outstanding reply, so dpkt is never stalled.
   assign receive_ready_out = 1'b1;
   assign send_tag          = send_tag_q;
   assign receive_valid_out = rx_valid_q;
   assign receive_data_out  = rx_data_q;
   assign deliver           = rx_valid_q & receive_ready_in;

   assign err_flags[ERR_COLLISION] = collision_q;
   assign err_flags[ERR_UNDERFLOW] = err_underflow;
   assign err_flags[ERR_OVERFLOW]  = err_overflow;

   // Only the low tag bits select a slot; the rest ride along for the master.
   assign unused_tag_bits = ^receive_tag;

   assign wr_slot = mode_q ? receive_tag[SLOT_W-1:0] : wr_ptr_q;
   assign rd_slot = mode_q ? head_tag_q[SLOT_W-1:0]  : rd_ptr_q;
   assign load    = rob_valid_q[rd_slot] & (~rx_valid_q | deliver);

   // Next state for tags, pointers, ROB valid bits, output register and mode.
   always_comb begin
      send_tag_d  = send_tag_q;
      head_tag_d  = head_tag_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rob_valid_d = rob_valid_q;
      rx_valid_d  = rx_valid_q;
      rx_data_d   = rx_data_q;
      collision_d = collision_q;
      mode_d      = mode_q;

      if (issue) send_tag_d = send_tag_q + WIDTH_TAG'(1);

      // head_tag advances in both modes so it stays aligned with send_tag
      // whenever the shell goes idle and the mode may flip.
      if (load) begin
         rob_valid_d[rd_slot] = 1'b0;
         rx_valid_d           = 1'b1;
         rx_data_d            = rob_data_q[rd_slot];
         head_tag_d           = head_tag_q + WIDTH_TAG'(1);
         if (!mode_q) rd_ptr_d = rd_ptr_q + SLOT_W'(1);
      end else if (deliver) begin
         rx_valid_d = 1'b0;
      end

      // A write into the slot being drained this cycle loses nothing, so it
      // is not a collision; the new entry is read on the following cycle.
      if (receive_valid_in) begin
         if (rob_valid_q[wr_slot] && !(load && (rd_slot == wr_slot))) collision_d = 1'b1;
         rob_valid_d[wr_slot] = 1'b1;
         if (!mode_q) wr_ptr_d = wr_ptr_q + SLOT_W'(1);
      end

      if ((credits_avail == CNT_W'(NUM_CREDITS)) && !rx_valid_q) mode_d = reorder_en;
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         send_tag_q  <= '0;
         head_tag_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rob_valid_q <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         collision_q <= 1'b0;
         mode_q      <= reorder_en;
      end else begin
         send_tag_q  <= send_tag_d;
         head_tag_q  <= head_tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rob_valid_q <= rob_valid_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         collision_q <= collision_d;
         mode_q      <= mode_d;
      end
   end

   // ROB payload storage, written on every arriving reply.
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; the valid bits alone say which entries are meaningful.
      if (receive_valid_in) rob_data_q[wr_slot] <= receive_data_in;
   end

endmodule

// File: tb/tb_tm_master_multislave_rob.sv
// Directed bench: default-sized shell (A) plus a 4-credit, 3-bit-tag shell (B) for tag wrap.
module tb_tm_master_multislave_rob;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: NUM_CREDITS=8, WIDTH_TAG=8
   logic        a_reorder_en, a_send_valid, a_send_ready_in, a_send_ready_out;
   logic [7:0]  a_send_tag, a_rx_tag;
   logic        a_rx_valid_in, a_rx_ready_out, a_rx_valid_out, a_rx_ready_in;
   logic [35:0] a_rx_data_in, a_rx_data_out;
   logic [3:0]  a_credits;
   logic [2:0]  a_err;

   // Instance B: NUM_CREDITS=4, WIDTH_TAG=3
   logic        b_reorder_en, b_send_valid, b_send_ready_in, b_send_ready_out;
   logic [2:0]  b_send_tag, b_rx_tag;
   logic        b_rx_valid_in, b_rx_ready_out, b_rx_valid_out, b_rx_ready_in;
   logic [35:0] b_rx_data_in, b_rx_data_out;
   logic [2:0]  b_credits;
   logic [2:0]  b_err;

   tm_master_multislave_rob #(.NUM_CREDITS(8), .WIDTH_DATA(36), .WIDTH_TAG(8)) dut_a (
      .clk(clk), .rst(rst), .reorder_en(a_reorder_en),
      .send_valid_in(a_send_valid), .send_ready_in(a_send_ready_in),
      .send_ready_out(a_send_ready_out), .send_tag(a_send_tag),
      .receive_valid_in(a_rx_valid_in), .receive_tag(a_rx_tag),
      .receive_data_in(a_rx_data_in), .receive_ready_out(a_rx_ready_out),
      .receive_valid_out(a_rx_valid_out), .receive_data_out(a_rx_data_out),
      .receive_ready_in(a_rx_ready_in), .credits_avail(a_credits), .err_flags(a_err)
   );

   tm_master_multislave_rob #(.NUM_CREDITS(4), .WIDTH_DATA(36), .WIDTH_TAG(3)) dut_b (
      .clk(clk), .rst(rst), .reorder_en(b_reorder_en),
      .send_valid_in(b_send_valid), .send_ready_in(b_send_ready_in),
      .send_ready_out(b_send_ready_out), .send_tag(b_send_tag),
      .receive_valid_in(b_rx_valid_in), .receive_tag(b_rx_tag),
      .receive_data_in(b_rx_data_in), .receive_ready_out(b_rx_ready_out),
      .receive_valid_out(b_rx_valid_out), .receive_data_out(b_rx_data_out),
      .receive_ready_in(b_rx_ready_in), .credits_avail(b_credits), .err_flags(b_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   logic [35:0] a_q [$];
   int          a_cyc [$];
   logic [35:0] b_q [$];

   always @(posedge clk) cycle <= cycle + 1;

   // Record each reply that will be delivered at the coming rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_rx_valid_out && a_rx_ready_in) begin
            a_q.push_back(a_rx_data_out);
            a_cyc.push_back(cycle);
         end
         if (b_rx_valid_out && b_rx_ready_in) b_q.push_back(b_rx_data_out);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_issue(input int n);
      a_send_valid = 1'b1;
      repeat (n) tick();
      a_send_valid = 1'b0;
   endtask

   task automatic a_reply(input logic [7:0] tag, input logic [35:0] data);
      a_rx_valid_in = 1'b1;
      a_rx_tag      = tag;
      a_rx_data_in  = data;
      tick();
      a_rx_valid_in = 1'b0;
   endtask

   task automatic a_reset_checks(input string tag);
      check({tag, "_send_tag"}, a_send_tag, 0);
      check({tag, "_credits"},  a_credits, 8);
      check({tag, "_rvalid"},   a_rx_valid_out, 0);
      check({tag, "_rdata"},    a_rx_data_out, 0);
      check({tag, "_err"},      a_err, 0);
   endtask

   initial begin
      rst = 1'b1;
      a_reorder_en = 1'b1; a_send_valid = 1'b0; a_send_ready_in = 1'b1;
      a_rx_valid_in = 1'b0; a_rx_tag = '0; a_rx_data_in = '0; a_rx_ready_in = 1'b1;
      b_reorder_en = 1'b1; b_send_valid = 1'b0; b_send_ready_in = 1'b1;
      b_rx_valid_in = 1'b0; b_rx_tag = '0; b_rx_data_in = '0; b_rx_ready_in = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      a_reset_checks("reset");
      check("reset_rready_out", a_rx_ready_out, 1);
      check("reset_send_ready", a_send_ready_out, 1);
      check("reset_b_credits", b_credits, 4);
      a_send_ready_in = 1'b0;
      #1 check("pkt_not_ready", a_send_ready_out, 0);
      a_send_ready_in = 1'b1;

      // Reorder: tags 0..3, replies 2,0,3,1 -> delivered 0,1,2,3
      a_issue(4);
      check("t1_send_tag", a_send_tag, 4);
      check("t1_credits_out", a_credits, 4);
      a_q.delete();
      a_reply(8'd2, 36'hA02);
      a_reply(8'd0, 36'hA00);
      a_reply(8'd3, 36'hA03);
      a_reply(8'd1, 36'hA01);
      repeat (6) tick();
      check("t1_count", a_q.size(), 4);
      for (int i = 0; i < 4 && i < a_q.size(); i++) check("t1_order", a_q[i], 36'hA00 + 36'(i));
      check("t1_credits_back", a_credits, 8);
      check("t1_err", a_err, 0);

      // Exhaust credits (tags 4..11), then one delivery restores send_ready
      a_issue(8);
      check("t2_ready_zero", a_send_ready_out, 0);
      check("t2_credits_zero", a_credits, 0);
      check("t2_send_tag", a_send_tag, 12);
      a_send_valid = 1'b1;
      tick();
      a_send_valid = 1'b0;
      check("t2_blocked_credits", a_credits, 0);
      check("t2_blocked_tag", a_send_tag, 12);
      check("t2_blocked_err", a_err, 0);
      a_reply(8'd4, 36'hB04);
      check("t2_latency_rvalid", a_rx_valid_out, 0);
      tick();
      check("t2_rvalid", a_rx_valid_out, 1);
      check("t2_rdata", a_rx_data_out, 36'hB04);
      check("t2_still_blocked", a_send_ready_out, 0);
      tick();
      check("t2_credits_one", a_credits, 1);
      check("t2_ready_back", a_send_ready_out, 1);

      // Output stall with three replies buffered
      a_rx_ready_in = 1'b0;
      a_reply(8'd5, 36'hB05);
      a_reply(8'd6, 36'hB06);
      a_reply(8'd7, 36'hB07);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_stall_data", a_rx_data_out, 36'hB05);
         check("t3_stall_valid", a_rx_valid_out, 1);
         check("t3_stall_credits", a_credits, 1);
      end
      a_q.delete();
      a_cyc.delete();
      a_rx_ready_in = 1'b1;
      repeat (4) tick();
      check("t3_count", a_q.size(), 3);
      if (a_q.size() == 3) begin
         check("t3_d0", a_q[0], 36'hB05);
         check("t3_d1", a_q[1], 36'hB06);
         check("t3_d2", a_q[2], 36'hB07);
         check("t3_back2back_1", a_cyc[1] - a_cyc[0], 1);
         check("t3_back2back_2", a_cyc[2] - a_cyc[1], 1);
      end
      check("t3_credits", a_credits, 4);
      for (int t = 8; t < 12; t++) a_reply(8'(t), 36'hC00 + 36'(t));
      repeat (4) tick();
      check("t3_drained", a_credits, 8);
      check("t3_idle_rvalid", a_rx_valid_out, 0);

      // Arrival mode selected while idle; toggle while busy is ignored
      a_reorder_en = 1'b0;
      tick();
      a_issue(1);
      a_reorder_en = 1'b1;
      a_issue(2);
      check("t4_send_tag", a_send_tag, 15);
      a_q.delete();
      a_reply(8'd5, 36'hD05);
      a_reply(8'd2, 36'hD02);
      a_reply(8'd7, 36'hD07);
      repeat (4) tick();
      check("t4_count", a_q.size(), 3);
      if (a_q.size() == 3) begin
         check("t4_d0", a_q[0], 36'hD05);
         check("t4_d1", a_q[1], 36'hD02);
         check("t4_d2", a_q[2], 36'hD07);
      end
      check("t4_credits", a_credits, 8);
      check("t4_err", a_err, 0);

      // Collision on slot 1 (back in reorder mode, head slot 7 empty)
      a_rx_ready_in = 1'b0;
      a_issue(3);
      a_reply(8'd17, 36'hE01);
      check("t5_no_err_yet", a_err, 0);
      check("t5_reorder_hold", a_rx_valid_out, 0);
      a_reply(8'd17, 36'hE02);
      check("t5_collision", a_err, 3'b001);
      repeat (2) tick();
      check("t5_sticky", a_err, 3'b001);
      a_reply(8'd15, 36'hE00);
      tick();
      check("t5_head_loaded", a_rx_data_out, 36'hE00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_reset_checks("t5_midreset");

      // Stray reply with all credits free -> overflow, counter held
      a_rx_ready_in = 1'b1;
      a_q.delete();
      a_reply(8'd0, 36'hF00);
      repeat (3) tick();
      check("t6_delivered", a_q.size(), 1);
      check("t6_overflow", a_err, 3'b100);
      check("t6_credits_held", a_credits, 8);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Tag wrap on B: 20 requests, replies reversed in groups of 4
      b_q.delete();
      for (int g = 0; g < 5; g++) begin
         b_send_valid = 1'b1;
         repeat (4) tick();
         b_send_valid = 1'b0;
         for (int k = 3; k >= 0; k--) begin
            b_rx_valid_in = 1'b1;
            b_rx_tag      = 3'(4 * g + k);
            b_rx_data_in  = 36'(4 * g + k);
            tick();
            b_rx_valid_in = 1'b0;
         end
         repeat (6) tick();
      end
      check("t7_count", b_q.size(), 20);
      for (int i = 0; i < 20 && i < b_q.size(); i++) check("t7_order", b_q[i], 36'(i));
      check("t7_err", b_err, 0);
      check("t7_credits", b_credits, 4);
      check("t7_send_tag", b_send_tag, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
